// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG scan master.
package cpu_debug_scan_pkg;

  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;
  localparam int unsigned TCK_DIV_DEF  = 2;

  // Debug slave instruction codes
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RSP
  } state_t;

  // Counter width for a modulo-n counter, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_debug_scan_tck_gen.sv
// Scan clock generator: tck toggles every TCK_DIV clk cycles while enabled,
// with one-clk strobes marking the cycle that drives each tck edge.
module cpu_debug_scan_tck_gen
  import cpu_debug_scan_pkg::*;
#(
  parameter int unsigned TCK_DIV = TCK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  localparam int unsigned PH_W = cnt_width(TCK_DIV);

  logic [PH_W-1:0] phase;
  logic            tick_c;

  // Terminal count of the half-period; the next clk edge toggles tck
  assign tick_c     = en && (phase == PH_W'(TCK_DIV - 1));
  assign tck_rise_c = tick_c && !tck;
  assign tck_fall_c = tick_c && tck;

  // Phase counter and tck register; parked low with a cleared phase when disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (!en) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (tick_c) begin
      phase <= '0;
      tck   <= ~tck;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Host-side virtual-JTAG initiator: turns one (IR, DR) command into a
// UIR/CDR/SDR/UDR scan and returns the DR bits shifted out of the slave.
module cpu_debug_scan_master
  import cpu_debug_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF,
  parameter int unsigned TCK_DIV  = TCK_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_rti
);

  localparam int unsigned CNT_W = cnt_width(DR_WIDTH);

  state_t              state;
  logic [DR_WIDTH-1:0] sr;
  logic [CNT_W-1:0]    slot;
  logic                tck_en_c;
  logic                tck_rise_c;
  logic                tck_fall_c;

  // Scan clock runs only while a scan is in progress
  assign tck_en_c = (state != ST_IDLE) && (state != ST_RSP);

  cpu_debug_scan_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (tck_en_c),
    .tck       (tck),
    .tck_rise_c(tck_rise_c),
    .tck_fall_c(tck_fall_c)
  );

  // Scan sequencer: state moves on tck falls (slot starts), tdo captured on tck rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sr        <= '0;
      slot      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tdi       <= 1'b0;
      ir_in     <= '0;
      vs_uir    <= 1'b0;
      vs_cdr    <= 1'b0;
      vs_sdr    <= 1'b0;
      vs_udr    <= 1'b0;
      jtag_rti  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ir_in     <= cmd_ir;
            sr        <= cmd_data;
            cmd_ready <= 1'b0;
            jtag_rti  <= 1'b0;
            vs_uir    <= 1'b1;
            state     <= ST_UIR;
          end
        end
        ST_UIR: begin
          if (tck_fall_c) begin
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
            state  <= ST_CDR;
          end
        end
        ST_CDR: begin
          if (tck_fall_c) begin
            vs_cdr <= 1'b0;
            vs_sdr <= 1'b1;
            tdi    <= sr[0];
            state  <= ST_SDR;
          end
        end
        ST_SDR: begin
          // tdo enters at the MSB so bit 0 ends up holding the first bit out
          if (tck_rise_c) begin
            sr <= DR_WIDTH'({tdo, sr} >> 1);
          end
          if (tck_fall_c) begin
            if (slot == CNT_W'(DR_WIDTH - 1)) begin
              slot   <= '0;
              vs_sdr <= 1'b0;
              vs_udr <= 1'b1;
              tdi    <= 1'b0;
              state  <= ST_UDR;
            end else begin
              slot <= slot + CNT_W'(1);
              tdi  <= sr[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall_c) begin
            vs_udr    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
            jtag_rti  <= 1'b1;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Randomized self-checking bench for cpu_debug_scan_master (default and
// TCK_DIV=1/DR_WIDTH=8 instances) against slave and loopback models.
module tb_cpu_debug_scan_master;
  import cpu_debug_scan_pkg::*;

  localparam int N0 = 38;
  localparam int D0 = 2;
  localparam int N1 = 8;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- default instance ----------------
  logic          cmd_valid0, cmd_ready0, rsp_valid0, rsp_ready0;
  logic [1:0]    cmd_ir0, ir_in0;
  logic [N0-1:0] cmd_data0, rsp_data0;
  logic          tck0, tdi0, tdo0;
  logic          vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, jtag_rti0;

  cpu_debug_scan_master dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir0), .cmd_data(cmd_data0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
    .tck(tck0), .tdi(tdi0), .tdo(tdo0), .ir_in(ir_in0),
    .vs_uir(vs_uir0), .vs_cdr(vs_cdr0), .vs_sdr(vs_sdr0), .vs_udr(vs_udr0), .jtag_rti(jtag_rti0)
  );

  // Debug slave model (tck domain) plus a one-slot loopback flop
  logic [N0-1:0] s_sr = '0;
  logic [N0-1:0] s_upd = '0;
  logic [N0-1:0] cap_val = '0;
  logic          lb0_q = 1'b0;
  bit            loopback = 1'b0;

  always @(posedge tck0) begin
    if (vs_cdr0) s_sr <= cap_val;
    else if (vs_sdr0) s_sr <= {tdi0, s_sr[N0-1:1]};
    if (vs_udr0) s_upd <= s_sr;
    lb0_q <= tdi0;
  end
  assign tdo0 = loopback ? lb0_q : s_sr[0];

  // ---------------- small, fast instance ----------------
  logic          cmd_valid1, cmd_ready1, rsp_valid1;
  logic          rsp_ready1 = 1'b1;
  logic [1:0]    cmd_ir1, ir_in1;
  logic [N1-1:0] cmd_data1, rsp_data1;
  logic          tck1, tdi1, tdo1;
  logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, jtag_rti1;
  logic          lb1_q = 1'b0;

  cpu_debug_scan_master #(.DR_WIDTH(N1), .IR_WIDTH(2), .TCK_DIV(D1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1),
    .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1), .jtag_rti(jtag_rti1)
  );

  always @(posedge tck1) lb1_q <= tdi1;
  assign tdo1 = lb1_q;

  function automatic logic [N0-1:0] rand38();
    return {6'($urandom), 32'($urandom)};
  endfunction

  // One full scan on dut0, measured at the transaction level
  task automatic run_scan0(input logic [1:0] ir, input logic [N0-1:0] data, input logic [N0-1:0] cap,
                           input bit lb, input int hold, input bit pend);
    int cyc, n_uir, n_cdr, n_sdr, n_udr, n_rise, last_rise, bad_gap, n_tdi;
    logic [N0-1:0] tdi_bits, exp_rsp, rsp_hold;
    logic prev_tck;
    bit stable;
    loopback = lb;
    cap_val  = cap;
    @(negedge clk);
    check("idle_ready", 64'(cmd_ready0), 64'(1));
    check("idle_rti", 64'(jtag_rti0), 64'(1));
    cmd_valid0 = 1'b1; cmd_ir0 = ir; cmd_data0 = data;
    @(negedge clk);
    // inputs after accept must be ignored
    cmd_valid0 = 1'b0; cmd_ir0 = ~ir; cmd_data0 = ~data;
    check("ready_drop", 64'(cmd_ready0), 64'(0));
    check("ir_in", 64'(ir_in0), 64'(ir));
    cyc = 1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rise = 0;
    last_rise = 0; bad_gap = 0; n_tdi = 0; tdi_bits = '0; prev_tck = 1'b0;
    while (!rsp_valid0 && cyc < 1000) begin
      if (vs_uir0) n_uir++;
      if (vs_cdr0) n_cdr++;
      if (vs_sdr0) n_sdr++;
      if (vs_udr0) n_udr++;
      if (tck0 && !prev_tck) begin
        if (n_rise > 0 && (cyc - last_rise) != 2 * D0) bad_gap++;
        last_rise = cyc;
        n_rise++;
        if (vs_sdr0 && n_tdi < N0) begin
          tdi_bits[n_tdi] = tdi0;
          n_tdi++;
        end
      end
      prev_tck = tck0;
      @(negedge clk);
      cyc++;
    end
    exp_rsp = lb ? (data << 1) : cap;
    check("latency", 64'(cyc), 64'((N0 + 3) * 2 * D0 + 1));
    check("uir_len", 64'(n_uir), 64'(2 * D0));
    check("cdr_len", 64'(n_cdr), 64'(2 * D0));
    check("sdr_len", 64'(n_sdr), 64'(N0 * 2 * D0));
    check("udr_len", 64'(n_udr), 64'(2 * D0));
    check("tck_rises", 64'(n_rise), 64'(N0 + 3));
    check("tck_period", 64'(bad_gap), 64'(0));
    check("tdi_bits", 64'(tdi_bits), 64'(data));
    check("rsp_data", 64'(rsp_data0), 64'(exp_rsp));
    if (!lb) check("slave_upd", 64'(s_upd), 64'(data));
    check("rsp_tck", 64'(tck0), 64'(0));
    // hold off the response and optionally present a competing command
    rsp_hold = rsp_data0;
    stable = 1'b1;
    if (pend) begin
      cmd_valid0 = 1'b1; cmd_ir0 = ~ir; cmd_data0 = rand38();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid0 || rsp_data0 !== rsp_hold || tck0 || cmd_ready0 || !jtag_rti0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'(1));
    rsp_ready0 = 1'b1;
    @(negedge clk);
    rsp_ready0 = 1'b0;
    check("rsp_drop", 64'(rsp_valid0), 64'(0));
    check("ready_back", 64'(cmd_ready0), 64'(1));
    check("ir_hold", 64'(ir_in0), 64'(ir));
    cmd_valid0 = 1'b0;
  endtask

  // One scan on dut1 with tdo looped back through a one-slot delay
  task automatic run_scan1(input logic [N1-1:0] data);
    int cyc, n_tdi, last_rise, bad_gap, n_rise;
    logic [N1-1:0] tdi_bits;
    logic prev_tck;
    @(negedge clk);
    check("idle_ready1", 64'(cmd_ready1), 64'(1));
    cmd_valid1 = 1'b1; cmd_ir1 = IR_TRACE; cmd_data1 = data;
    @(negedge clk);
    cmd_valid1 = 1'b0; cmd_data1 = ~data;
    cyc = 1; n_tdi = 0; last_rise = 0; bad_gap = 0; n_rise = 0; tdi_bits = '0; prev_tck = 1'b0;
    while (!rsp_valid1 && cyc < 200) begin
      if (tck1 && !prev_tck) begin
        if (n_rise > 0 && (cyc - last_rise) != 2 * D1) bad_gap++;
        last_rise = cyc;
        n_rise++;
        if (vs_sdr1 && n_tdi < N1) begin
          tdi_bits[n_tdi] = tdi1;
          n_tdi++;
        end
      end
      prev_tck = tck1;
      @(negedge clk);
      cyc++;
    end
    check("latency1", 64'(cyc), 64'((N1 + 3) * 2 * D1 + 1));
    check("tck_period1", 64'(bad_gap), 64'(0));
    check("tdi_bits1", 64'(tdi_bits), 64'(data));
    check("rsp_data1", 64'(rsp_data1), 64'(8'(data << 1)));
    check("ir_in1", 64'(ir_in1), 64'(IR_TRACE));
    @(negedge clk);
  endtask

  // Abort a scan with reset in the middle of the data shift
  task automatic reset_mid_sdr();
    int k, guard;
    logic prev;
    bit quiet;
    @(negedge clk);
    loopback = 1'b0;
    cmd_valid0 = 1'b1; cmd_ir0 = IR_BREAK; cmd_data0 = rand38();
    @(negedge clk);
    cmd_valid0 = 1'b0;
    k = 0; guard = 0; prev = 1'b0;
    while (k < 11 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (tck0 && !prev && vs_sdr0) k++;
      prev = tck0;
    end
    check("rst_reach_slot10", 64'(k), 64'(11));
    reset = 1'b1;
    @(negedge clk);
    check("rst_tck", 64'(tck0), 64'(0));
    check("rst_vs", 64'({vs_uir0, vs_cdr0, vs_sdr0, vs_udr0}), 64'(0));
    check("rst_ready", 64'(cmd_ready0), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid0), 64'(0));
    check("rst_rsp_data", 64'(rsp_data0), 64'(0));
    check("rst_rti", 64'(jtag_rti0), 64'(1));
    check("rst_ir_in", 64'(ir_in0), 64'(0));
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid0 || !cmd_ready0 || tck0) quiet = 1'b0;
    end
    check("rst_no_rsp", 64'(quiet), 64'(1));
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid0 = 1'b0; cmd_ir0 = '0; cmd_data0 = '0; rsp_ready0 = 1'b0;
    cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_data1 = '0;
    repeat (3) @(negedge clk);
    check("init_ready", 64'(cmd_ready0), 64'(1));
    check("init_rsp_valid", 64'(rsp_valid0), 64'(0));
    check("init_tck", 64'(tck0), 64'(0));
    check("init_tdi", 64'(tdi0), 64'(0));
    check("init_rti", 64'(jtag_rti0), 64'(1));
    check("init_vs", 64'({vs_uir0, vs_cdr0, vs_sdr0, vs_udr0}), 64'(0));
    check("init_rsp_data", 64'(rsp_data0), 64'(0));
    reset = 1'b0;

    run_scan0(IR_BREAK, 38'h2A_5A5A_5A5A, rand38(), 1'b1, 0, 1'b0);
    run_scan0(IR_OCIMEM, rand38(), 38'h15_DEAD_BEEF, 1'b0, 20, 1'b1);
    run_scan0(IR_TRACECTRL, rand38(), rand38(), 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_scan0(2'($urandom), rand38(), rand38(), 1'($urandom), int'($urandom_range(0, 6)), 1'($urandom));

    reset_mid_sdr();
    run_scan0(IR_TRACE, rand38(), rand38(), 1'b0, 2, 1'b0);

    run_scan1(8'hC3);
    for (int i = 0; i < 3; i++) run_scan1(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
